// File: rtl/lfsr_rand_arbiter.sv
// Shared 32-bit Fibonacci LFSR with warm-up sequencing and a round-robin grant per cycle.
// Optional macro LFSR_GRANT_COUNT_EN adds a saturating grant_count output.
module lfsr_rand_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter int          OUT_WIDTH     = 8,
    parameter int          WARMUP_CYCLES = 16,
    parameter logic [31:0] SEED          = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reseed,
    input  logic [31:0]          seed_i,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [OUT_WIDTH-1:0] rand_out,
    output logic                 ready
`ifdef LFSR_GRANT_COUNT_EN
    ,
    output logic [31:0]          grant_count
`endif
);

    localparam int               PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   SUM_WRAP  = (PTR_W + 1)'(NUM_REQ);
    localparam logic [7:0]       WCNT_LAST = 8'(WARMUP_CYCLES - 1);

    typedef enum logic {
        ST_WARMUP,
        ST_SERVE
    } state_t;

    // With no warm-up requested the block comes out of reset/reseed already serving.
    localparam state_t ST_INIT = (WARMUP_CYCLES == 0) ? ST_SERVE : ST_WARMUP;

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return {r[31] ^ r[21] ^ r[1] ^ r[0], r[31:1]};
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      r_q, r_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic             hit;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W:0]   sum;
    logic             grant_en;

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        hit     = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (sum >= SUM_WRAP) begin
                sum = sum - SUM_WRAP;
            end
            if (!hit && req[sum[PTR_W-1:0]]) begin
                hit     = 1'b1;
                gnt_idx = sum[PTR_W-1:0];
            end
        end
    end

    assign grant_en = (state_q == ST_SERVE) && !reseed && !rst && hit;

    always_comb begin
        gnt = '0;
        if (grant_en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Reseed wins over warm-up advance and over granting.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        wcnt_d  = wcnt_q;
        ptr_d   = ptr_q;
        if (reseed) begin
            r_d     = (seed_i == 32'h0) ? 32'h0000_0001 : seed_i;
            wcnt_d  = '0;
            state_d = ST_INIT;
        end else if (state_q == ST_WARMUP) begin
            r_d = lfsr_step(r_q);
            if (wcnt_q == WCNT_LAST) begin
                state_d = ST_SERVE;
                wcnt_d  = '0;
            end else begin
                wcnt_d = wcnt_q + 8'd1;
            end
        end else if (grant_en) begin
            r_d   = lfsr_step(r_q);
            ptr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            r_q     <= SEED;
            wcnt_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            wcnt_q  <= wcnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rand_out = r_q[31 -: OUT_WIDTH];
    assign ready    = (state_q == ST_SERVE);

`ifdef LFSR_GRANT_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts grants since rst; reseed leaves it alone.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_en && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule
